// File: rtl/cpu_pkg.sv
// Shared constants for the pipelined CPU control path.
//
// Contents:
//   COND_*  ARM condition-field encodings (EQ..AL, plus the 1111 code)
//   FLAG_*  bit positions of N,Z,C,V inside a 4-bit {N,Z,C,V} flag word
//   FW_*    flag_write encodings (bit1 selects N,Z, bit0 selects C,V)
package cpu_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [1:0] FW_NONE = 2'b00;
    localparam logic [1:0] FW_CV   = 2'b01;
    localparam logic [1:0] FW_NZ   = 2'b10;
    localparam logic [1:0] FW_ALL  = 2'b11;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition checker.
//
// Ports:
//   cond     in  4  condition field of the instruction
//   flags    in  4  current flags {N,Z,C,V}
//   cond_ex  out 1  1 when the instruction should execute
module cond_check
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // The unused 1111 code falls into the default and behaves as always.
    always_comb begin
        cond_ex = 1'b1;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = ~(n ^ v);
            COND_LT: cond_ex = n ^ v;
            COND_GT: cond_ex = ~z & ~(n ^ v);
            COND_LE: cond_ex = z | (n ^ v);
            default: cond_ex = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Execute-stage conditional-execution unit.
//
// Holds the architectural NZCV register, evaluates the instruction's
// condition against it, gates the instruction's PC/register/memory writes,
// updates flags selectively and keeps saturating executed/skipped counters.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   valid_e, stall_e, flush_e   occupancy and hold/squash of Execute
//   cond_e                      4-bit condition field
//   alu_flags_e, flag_write_e   new {N,Z,C,V} and per-pair write enables
//   pcs_e, reg_write_e,
//   mem_write_e, no_write_e     ungated side-effect requests
//   clear_cnt                   synchronous clear of both counters
//   cond_ex_e                   condition result against flags_q
//   pcsrc_o, reg_write_o,
//   mem_write_o                 gated side effects
//   flags_q                     architectural flags
//   exec_cnt, skip_cnt          saturating debug counters
module cond_unit
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_e,
    input  logic             stall_e,
    input  logic             flush_e,
    input  logic [3:0]       cond_e,
    input  logic [3:0]       alu_flags_e,
    input  logic [1:0]       flag_write_e,
    input  logic             pcs_e,
    input  logic             reg_write_e,
    input  logic             mem_write_e,
    input  logic             no_write_e,
    input  logic             clear_cnt,
    output logic             cond_ex_e,
    output logic             pcsrc_o,
    output logic             reg_write_o,
    output logic             mem_write_o,
    output logic [3:0]       flags_q,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] skip_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic live;
    logic fire;

    cond_check u_cond_check (
        .cond    (cond_e),
        .flags   (flags_q),
        .cond_ex (cond_ex_e)
    );

    // Reset is folded into live so an instruction in flight when reset
    // rises produces no write pulse, even before any clock edge.
    assign live = valid_e & ~stall_e & ~flush_e & ~reset;
    assign fire = live & cond_ex_e;

    assign pcsrc_o     = pcs_e & fire;
    assign mem_write_o = mem_write_e & fire;
    assign reg_write_o = reg_write_e & ~no_write_e & fire;

    // Flags update in two independent pairs; a pair that is not enabled
    // keeps its previous value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else if (fire) begin
            if (flag_write_e[1]) begin
                flags_q[FLAG_N] <= alu_flags_e[FLAG_N];
                flags_q[FLAG_Z] <= alu_flags_e[FLAG_Z];
            end
            if (flag_write_e[0]) begin
                flags_q[FLAG_C] <= alu_flags_e[FLAG_C];
                flags_q[FLAG_V] <= alu_flags_e[FLAG_V];
            end
        end
    end

    // Every live instruction lands in exactly one counter. clear_cnt wins
    // over a same-cycle increment; both counters stick at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exec_cnt <= '0;
            skip_cnt <= '0;
        end else if (clear_cnt) begin
            exec_cnt <= '0;
            skip_cnt <= '0;
        end else if (live) begin
            if (cond_ex_e) begin
                if (exec_cnt != CNT_MAX) exec_cnt <= exec_cnt + 1'b1;
            end else begin
                if (skip_cnt != CNT_MAX) skip_cnt <= skip_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// Directed self-checking bench for cond_unit (built with CNT_W=4 so the
// saturation boundary is reachable quickly).
module tb_cond_unit;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             valid_e, stall_e, flush_e;
    logic [3:0]       cond_e, alu_flags_e;
    logic [1:0]       flag_write_e;
    logic             pcs_e, reg_write_e, mem_write_e, no_write_e;
    logic             clear_cnt;
    logic             cond_ex_e, pcsrc_o, reg_write_o, mem_write_o;
    logic [3:0]       flags_q;
    logic [CNT_W-1:0] exec_cnt, skip_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cond_unit #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_e      (valid_e),
        .stall_e      (stall_e),
        .flush_e      (flush_e),
        .cond_e       (cond_e),
        .alu_flags_e  (alu_flags_e),
        .flag_write_e (flag_write_e),
        .pcs_e        (pcs_e),
        .reg_write_e  (reg_write_e),
        .mem_write_e  (mem_write_e),
        .no_write_e   (no_write_e),
        .clear_cnt    (clear_cnt),
        .cond_ex_e    (cond_ex_e),
        .pcsrc_o      (pcsrc_o),
        .reg_write_o  (reg_write_o),
        .mem_write_o  (mem_write_o),
        .flags_q      (flags_q),
        .exec_cnt     (exec_cnt),
        .skip_cnt     (skip_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] c, input logic [3:0] af,
                                 input logic [1:0] fw, input logic p, input logic rw,
                                 input logic mw, input logic nw);
        valid_e      = v;
        cond_e       = c;
        alu_flags_e  = af;
        flag_write_e = fw;
        pcs_e        = p;
        reg_write_e  = rw;
        mem_write_e  = mw;
        no_write_e   = nw;
        #1;
    endtask

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkState(input string tag, input logic [3:0] f, input int e, input int s);
        checkOutput({tag, ".flags"}, 32'(flags_q), 32'(f));
        checkOutput({tag, ".exec"}, 32'(exec_cnt), 32'(e));
        checkOutput({tag, ".skip"}, 32'(skip_cnt), 32'(s));
    endtask

    initial begin
        reset = 1'b1; stall_e = 1'b0; flush_e = 1'b0; clear_cnt = 1'b0;
        applyStimulus(1'b1, 4'b1110, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("rst.pcsrc", 32'(pcsrc_o), 0);
        checkOutput("rst.regw", 32'(reg_write_o), 0);
        checkOutput("rst.memw", 32'(mem_write_o), 0);
        tick(); tick();
        checkState("rst", 4'b0000, 0, 0);
        applyStimulus(1'b0, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();

        // 1: EQ with Z=0 is annulled
        applyStimulus(1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("t1.condex", 32'(cond_ex_e), 0);
        checkOutput("t1.regw", 32'(reg_write_o), 0);
        tick();
        checkState("t1", 4'b0000, 0, 1);

        // 2: CMP sets Z, then EQ executes
        applyStimulus(1'b1, 4'b1110, 4'b0100, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("t2.condex", 32'(cond_ex_e), 1);
        checkOutput("t2.regw_cmp", 32'(reg_write_o), 0);
        tick();
        checkState("t2a", 4'b0100, 1, 1);
        applyStimulus(1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("t2.regw_eq", 32'(reg_write_o), 1);
        tick();
        checkState("t2b", 4'b0100, 2, 1);

        // 3: partial flag updates
        applyStimulus(1'b1, 4'b1110, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkState("t3a", 4'b0000, 3, 1);
        applyStimulus(1'b1, 4'b1110, 4'b1111, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkState("t3b", 4'b1100, 4, 1);
        applyStimulus(1'b1, 4'b1110, 4'b0010, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkState("t3c", 4'b1110, 5, 1);

        // Condition table spot checks with N=1 Z=1 C=1 V=0 (nothing live)
        applyStimulus(1'b0, 4'b1010, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("cc.GE", 32'(cond_ex_e), 0);
        cond_e = 4'b1011; #1 checkOutput("cc.LT", 32'(cond_ex_e), 1);
        cond_e = 4'b1000; #1 checkOutput("cc.HI", 32'(cond_ex_e), 0);
        cond_e = 4'b1001; #1 checkOutput("cc.LS", 32'(cond_ex_e), 1);
        cond_e = 4'b1100; #1 checkOutput("cc.GT", 32'(cond_ex_e), 0);
        cond_e = 4'b1101; #1 checkOutput("cc.LE", 32'(cond_ex_e), 1);
        cond_e = 4'b0101; #1 checkOutput("cc.PL", 32'(cond_ex_e), 0);
        cond_e = 4'b0111; #1 checkOutput("cc.VC", 32'(cond_ex_e), 1);
        cond_e = 4'b1111; #1 checkOutput("cc.NV", 32'(cond_ex_e), 1);
        tick();
        checkState("cc", 4'b1110, 5, 1);

        // 4: annulled flag-setter
        applyStimulus(1'b1, 4'b1110, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkState("t4a", 4'b0100, 6, 1);
        applyStimulus(1'b1, 4'b0001, 4'b0011, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t4.condex", 32'(cond_ex_e), 0);
        checkOutput("t4.memw", 32'(mem_write_o), 0);
        tick();
        checkState("t4b", 4'b0100, 6, 2);

        // 5: stall, release, flush, stall+flush
        applyStimulus(1'b1, 4'b1110, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
        stall_e = 1'b1; #1;
        checkOutput("t5.stall_pc", 32'(pcsrc_o), 0);
        checkOutput("t5.stall_rw", 32'(reg_write_o), 0);
        tick();
        checkState("t5a", 4'b0100, 6, 2);
        flag_write_e = 2'b00; stall_e = 1'b0; #1;
        checkOutput("t5.go_pc", 32'(pcsrc_o), 1);
        checkOutput("t5.go_mw", 32'(mem_write_o), 1);
        tick();
        checkState("t5b", 4'b0100, 7, 2);
        flag_write_e = 2'b11; flush_e = 1'b1; #1;
        checkOutput("t5.flush_pc", 32'(pcsrc_o), 0);
        tick();
        checkState("t5c", 4'b0100, 7, 2);
        stall_e = 1'b1; #1;
        checkOutput("t5.both_pc", 32'(pcsrc_o), 0);
        tick();
        checkState("t5d", 4'b0100, 7, 2);
        stall_e = 1'b0; flush_e = 1'b0;

        // 6: saturation, clear priority, mid-cycle reset
        applyStimulus(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        checkState("t6.exec_sat", 4'b0100, 15, 2);
        cond_e = 4'b0001;
        for (int i = 0; i < 20; i++) tick();
        checkState("t6.skip_sat", 4'b0100, 15, 15);
        cond_e = 4'b1110; clear_cnt = 1'b1; #1;
        tick();
        checkState("t6.clear", 4'b0100, 0, 0);
        clear_cnt = 1'b0;
        applyStimulus(1'b1, 4'b1110, 4'b1010, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkState("t6.pre", 4'b1010, 1, 0);
        applyStimulus(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("t6.pc_live", 32'(pcsrc_o), 1);
        reset = 1'b1; #1;
        checkOutput("t6.rst_pc", 32'(pcsrc_o), 0);
        checkOutput("t6.rst_rw", 32'(reg_write_o), 0);
        checkState("t6.rst", 4'b0000, 0, 0);
        tick();
        checkState("t6.rst_hold", 4'b0000, 0, 0);
        reset = 1'b0;
        valid_e = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
